// File: rtl/muldiv_seq.sv
// muldiv_seq: EX-stage sequencer that issues one HI/LO op to multiplier_ip/divider_ip, stalls until done, holds the result until EX advances
// Ports:
//   clk, rst (async, active-low)
//   req_mul/req_div/req_sign/req_mode/req_srca/req_srcb/req_hi/req_lo : EX request and operands
//   ex_advance, flush : pipeline control
//   mul_start/div_start, u_sign/u_mode/u_srca/u_srcb/u_hi/u_lo : start pulse and latched operands to the units
//   mul_done/div_done, mul_hi/mul_lo/div_hi/div_lo : unit results
//   stall, res_valid, res_hi/res_lo, busy, timeout_err : status and result back to the pipeline
module muldiv_seq #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_mul,
  input  logic        req_div,
  input  logic        req_sign,
  input  logic [1:0]  req_mode,
  input  logic [31:0] req_srca,
  input  logic [31:0] req_srcb,
  input  logic [31:0] req_hi,
  input  logic [31:0] req_lo,
  input  logic        ex_advance,
  input  logic        flush,
  output logic        mul_start,
  output logic        div_start,
  output logic        u_sign,
  output logic [1:0]  u_mode,
  output logic [31:0] u_srca,
  output logic [31:0] u_srcb,
  output logic [31:0] u_hi,
  output logic [31:0] u_lo,
  input  logic        mul_done,
  input  logic        div_done,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic        stall,
  output logic        res_valid,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        busy,
  output logic        timeout_err
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;
  state_t      state_q, state_d;
  logic        div_q, div_d;
  logic        sign_q, sign_d;
  logic [1:0]  mode_q, mode_d;
  logic [31:0] srca_q, srca_d, srcb_q, srcb_d, hi_q, hi_d, lo_q, lo_d;
  logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic [7:0]  wd_q, wd_d;
  logic        req, done_sel, waiting, wd_hit, latch, capture;
  assign req      = req_mul | req_div;
  // only the unit this op was issued to can complete it
  assign done_sel = div_q ? div_done : mul_done;
  assign waiting  = state_q == WAIT || state_q == DRAIN;
  // a done arriving on the last allowed cycle still wins over the watchdog
  assign wd_hit   = waiting && wd_q == 8'(TIMEOUT - 1) && !done_sel;
  assign latch    = state_q == IDLE && req && !flush;
  assign capture  = state_q == WAIT && done_sel && !flush;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      div_q    <= 1'b0;
      sign_q   <= 1'b0;
      mode_q   <= 2'd0;
      srca_q   <= '0;
      srcb_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      sign_q   <= sign_d;
      mode_q   <= mode_d;
      srca_q   <= srca_d;
      srcb_q   <= srcb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      wd_q     <= wd_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = latch ? ISSUE : IDLE;
      ISSUE:   state_d = flush ? DRAIN : WAIT;
      WAIT:    state_d = done_sel ? (flush ? IDLE : DONE) : wd_hit ? IDLE : flush ? DRAIN : WAIT;
      DONE:    state_d = (ex_advance || flush) ? IDLE : DONE;
      DRAIN:   state_d = (done_sel || wd_hit) ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    div_d    = latch ? req_div  : div_q;
    sign_d   = latch ? req_sign : sign_q;
    mode_d   = latch ? req_mode : mode_q;
    srca_d   = latch ? req_srca : srca_q;
    srcb_d   = latch ? req_srcb : srcb_q;
    hi_d     = latch ? req_hi   : hi_q;
    lo_d     = latch ? req_lo   : lo_q;
    res_hi_d = capture ? (div_q ? div_hi : mul_hi) : res_hi_q;
    res_lo_d = capture ? (div_q ? div_lo : mul_lo) : res_lo_q;
    wd_d     = state_q == ISSUE ? 8'd0 : (waiting && wd_q != 8'hFF) ? wd_q + 8'd1 : wd_q;
  end
  always_comb begin
    mul_start   = state_q == ISSUE && !div_q;
    div_start   = state_q == ISSUE && div_q;
    u_sign      = sign_q;
    u_mode      = mode_q;
    u_srca      = srca_q;
    u_srcb      = srcb_q;
    u_hi        = hi_q;
    u_lo        = lo_q;
    // gated by rst so the pipeline sees no stall while the block is held in reset
    stall       = rst && req && !flush && state_q != DONE;
    res_valid   = state_q == DONE;
    res_hi      = res_hi_q;
    res_lo      = res_lo_q;
    busy        = state_q == ISSUE || waiting;
    timeout_err = wd_hit;
  end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Sequencer for the EX-stage multi-cycle arithmetic units (multiplier_ip, divider_ip). It accepts one HI/LO operation per EX instruction and latches the operands. It issues a one-cycle start to the selected unit and stalls the pipeline until the result is ready. It then holds the result until the instruction actually leaves EX, and cancels or drains in-flight work on a pipeline flush.

## Interface
Parameters:
- TIMEOUT, 64: maximum cycles a unit may stay busy before the watchdog aborts the operation.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_mul  in  1  EX instruction is a multiply class op (mul_en).
- req_div  in  1  EX instruction is a divide (div_en); req_mul and req_div are never both 1.
- req_sign  in  1  signed operation.
- req_mode  in  2  multiply mode: 0 plain, 1 madd, 2 msub; ignored for div.
- req_srca, req_srcb  in  32 each  forwarded rs/rt data.
- req_hi, req_lo  in  32 each  current HI/LO, used for madd/msub.
- ex_advance  in  1  the EX instruction moves to MEM this cycle.
- flush  in  1  kill the EX instruction (exception or branch-likely squash).
- mul_start, div_start  out  1 each  one-cycle start pulse to the unit.
- u_sign  out  1  latched sign to the unit.
- u_mode  out  2  latched mode to the unit.
- u_srca, u_srcb, u_hi, u_lo  out  32 each  latched operands to the unit.
- mul_done, div_done  in  1 each  unit out_valid; a one-cycle pulse.
- mul_hi, mul_lo, div_hi, div_lo  in  32 each  unit results, valid with done.
- stall  out  1  hold IF/ID/EX.
- res_valid  out  1  res_hi/res_lo are valid; gates hi_wen/lo_wen.
- res_hi, res_lo  out  32 each  registered result.
- busy  out  1  a unit is occupied, including while draining.
- timeout_err  out  1  one-cycle pulse when the watchdog fires.

## Operation
States: IDLE, ISSUE, WAIT, DONE, DRAIN.

Transitions:
- IDLE: if (req_mul|req_div) & !flush, latch operands, sign, mode and op kind, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE: assert mul_start or div_start for exactly one cycle, clear the watchdog counter, go to WAIT. If flush, go to DRAIN; the start pulse is still issued.
- WAIT: on done of the selected unit, register hi/lo into res_hi/res_lo and go to DONE. If flush, go to DRAIN. If flush and done occur in the same cycle, go to IDLE and discard the result.
- DONE: res_valid=1. On ex_advance or flush, go to IDLE.
- DRAIN: ignore the result. On done of the latched unit, go to IDLE.

Rules:
- Done of the unit that was not selected is ignored in every state.
- stall = (req_mul|req_div) & !flush & (state != DONE). This includes IDLE on the request cycle, ISSUE, WAIT and DRAIN.
- A request that arrives while in DRAIN waits: the FSM returns to IDLE first, and the request is accepted on the following cycle.
- busy = state ∈ {ISSUE, WAIT, DRAIN}.
- Watchdog: an 8-bit saturating counter increments each cycle in WAIT/DRAIN. When the count reaches TIMEOUT-1 without done: pulse timeout_err, go to IDLE, set res_valid=0. res_hi/res_lo are unchanged.
- res_hi/res_lo change only on the WAIT→DONE transition.
- Operand registers change only on IDLE→ISSUE.

## Timing
- Reset (rst=0, asynchronous) values: state=IDLE; every output and every internal register = 0.
- Request accepted at cycle T. Start pulse at T+1. For a unit with done at T+1+L, res_valid rises at T+2+L.
- stall is high from T through T+1+L and falls in the cycle res_valid rises.
- Minimum occupancy, with L=1, is 3 cycles before DONE.
- In DONE with ex_advance=0 (stalled by another hazard), the FSM holds DONE. It does not re-issue even though req stays asserted.
- Back-to-back ops: DONE with ex_advance at cycle N, then IDLE at N+1. The next request is accepted at N+1.

## Test plan
- Signed mul, srca=3, srcb=-2, stub latency L=4, ex_advance=1 → mul_start only at T+1; stall high T..T+5; res_valid at T+6 with res_hi=0xFFFFFFFF, res_lo=0xFFFFFFFA.
- Unsigned div, 100/7, L=8, ex_advance held 0 for 3 cycles after done → res_valid stays 1 with lo=14, hi=2; exactly one div_start; stall=0 throughout DONE.
- Flush at T+3 during a div → state DRAIN; a new mul request at T+4 keeps stall high; after div_done the mul is accepted one cycle later; the discarded div result never drives res_valid.
- Flush in the same cycle as mul_done → no res_valid; IDLE next cycle.
- Stub never asserts done, TIMEOUT=64 → timeout_err pulse 63 cycles after entering WAIT; IDLE next cycle.
- rst asserted mid-WAIT → all outputs 0 immediately (asynchronously); a stray done after reset release is ignored.
